// File: rtl/burst_mem_responder.sv
// Burst memory responder: serves one 256-bit line per transfer as four
// 64-bit beats after a fixed access latency, from an internal line array.
module burst_mem_responder #(
    parameter int unsigned LINE_IDX_W = 8,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        proto_err
);

    localparam int unsigned BEAT_W  = $clog2(BURST_LEN);
    localparam int unsigned ADDR_W  = LINE_IDX_W + BEAT_W;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;

    localparam logic [3:0]        LAT_INIT  = 4'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [3:0]            lat_q, lat_d;
    logic [LINE_IDX_W-1:0] line_q, line_d;
    logic                  op_rd_q, op_rd_d;
    logic                  resp_q, resp_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  perr_q, perr_d;

    // Storage is not reset; it powers up as zero.
    logic [63:0] mem_q [DEPTH] = '{default: '0};

    logic              req;
    logic [BEAT_W-1:0] rd_beat;
    logic              wr_en;

    // Line offset bits and the aliased upper address bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[4:0], mem_addr[31:5+LINE_IDX_W]};

    assign req   = mem_read | mem_write;
    assign wr_en = (state_q == S_BURST) && req && !op_rd_q;

    // Control registers: all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            line_q  <= '0;
            op_rd_q <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            op_rd_q <= op_rd_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
        end
    end

    // Commit a write beat on the edge that ends its acknowledge cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{line_q, beat_q}] <= mem_wdata;
        end
    end

    // Next-state logic; resp/rdata are computed for the upcoming cycle so they register.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        line_d  = line_q;
        op_rd_d = op_rd_q;
        perr_d  = perr_q;
        resp_d  = 1'b0;
        rdata_d = '0;
        rd_beat = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    line_d  = mem_addr[5 +: LINE_IDX_W];
                    op_rd_d = mem_read;
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                    if (mem_read && mem_write) begin
                        perr_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    perr_d  = 1'b1;
                end else if (lat_q == '0) begin
                    state_d = S_BURST;
                    beat_d  = '0;
                    rd_beat = '0;
                    resp_d  = 1'b1;
                    if (op_rd_q) begin
                        rdata_d = mem_q[{line_q, rd_beat}];
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_BURST: begin
                if (!req) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                    perr_d  = 1'b1;
                end else if (beat_q == LAST_BEAT) begin
                    state_d = S_DONE;
                    beat_d  = '0;
                end else begin
                    rd_beat = beat_q + 1'b1;
                    beat_d  = rd_beat;
                    resp_d  = 1'b1;
                    if (op_rd_q) begin
                        rdata_d = mem_q[{line_q, rd_beat}];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder with LATENCY=4, LINE_IDX_W=8.
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_resp;
    logic        busy;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] P1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] P2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] P3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] P4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] P5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] P6 = 64'h6666_6666_6666_6666;
    localparam logic [63:0] P7 = 64'h7777_7777_7777_7777;
    localparam logic [63:0] P8 = 64'h8888_8888_8888_8888;
    localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] PD = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] Z  = 64'h0;

    burst_mem_responder #(
        .LINE_IDX_W(8),
        .LATENCY   (4),
        .BURST_LEN (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp),
        .busy     (busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][63:0] pk(input logic [63:0] b0, b1, b2, b3);
        logic [3:0][63:0] r;
        r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transfer: request raised in cycle 0, beats expected in cycles 5..8,
    // busy in cycles 1..9, request dropped in cycle 9 (DONE).
    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [3:0][63:0] wd,
                        input logic [3:0][63:0] exp_rd, input logic exp_perr);
        logic beat_cyc;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd[0];
        for (int c = 1; c <= 10; c++) begin
            tick();
            beat_cyc = (c >= 5) && (c <= 8);
            chk($sformatf("%s_resp_c%0d", tag, c), {63'b0, mem_resp}, {63'b0, beat_cyc});
            chk($sformatf("%s_busy_c%0d", tag, c), {63'b0, busy}, {63'b0, (c <= 9)});
            chk($sformatf("%s_rdata_c%0d", tag, c), mem_rdata,
                (beat_cyc && rd) ? exp_rd[c-5] : Z);
            if (c >= 6 && c <= 8) mem_wdata = wd[c-5];
            if (c == 9) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        chk({tag, "_perr"}, {63'b0, proto_err}, {63'b0, exp_perr});
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        #2;
        chk("rst_resp",  {63'b0, mem_resp},  Z);
        chk("rst_rdata", mem_rdata,          Z);
        chk("rst_busy",  {63'b0, busy},      Z);
        chk("rst_perr",  {63'b0, proto_err}, Z);
        @(posedge clk);
        tick();
        rst = 1'b0;

        // Cold read of line 2 returns zeros
        xfer("rd40_cold", 1'b1, 1'b0, 32'h0000_0040, pk(Z, Z, Z, Z), pk(Z, Z, Z, Z), 1'b0);
        // Write then read back in beat order; neighbour line untouched
        xfer("wr40", 1'b0, 1'b1, 32'h0000_0040, pk(P1, P2, P3, P4), pk(Z, Z, Z, Z), 1'b0);
        xfer("rd40", 1'b1, 1'b0, 32'h0000_0040, pk(Z, Z, Z, Z), pk(P1, P2, P3, P4), 1'b0);
        xfer("rd60", 1'b1, 1'b0, 32'h0000_0060, pk(Z, Z, Z, Z), pk(Z, Z, Z, Z), 1'b0);
        // Upper address bits alias back onto line 2
        xfer("rd2040", 1'b1, 1'b0, 32'h0000_2040, pk(Z, Z, Z, Z), pk(P1, P2, P3, P4), 1'b0);

        // Prime line 4 then abort a write after two beats
        xfer("wr80", 1'b0, 1'b1, 32'h0000_0080, pk(P5, P6, P7, P8), pk(Z, Z, Z, Z), 1'b0);
        mem_write = 1'b1;
        mem_addr  = 32'h0000_0080;
        mem_wdata = PA;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 5 || c == 6) chk($sformatf("abort_resp_c%0d", c), {63'b0, mem_resp}, 64'd1);
            if (c == 7) mem_write = 1'b0;
        end
        for (int c = 8; c <= 10; c++) begin
            tick();
            chk($sformatf("abort_resp_c%0d", c), {63'b0, mem_resp}, Z);
            chk($sformatf("abort_busy_c%0d", c), {63'b0, busy}, Z);
        end
        chk("abort_perr", {63'b0, proto_err}, 64'd1);

        // Asynchronous reset in the middle of a read burst
        mem_read = 1'b1;
        mem_addr = 32'h0000_0040;
        for (int c = 1; c <= 6; c++) tick();
        chk("pre_rst_resp", {63'b0, mem_resp}, 64'd1);
        #3;
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        chk("arst_resp",  {63'b0, mem_resp},  Z);
        chk("arst_rdata", mem_rdata,          Z);
        chk("arst_busy",  {63'b0, busy},      Z);
        chk("arst_perr",  {63'b0, proto_err}, Z);
        #2;
        rst = 1'b0;
        tick();

        // Partial write stays committed: beats 0,1 new, 2,3 old
        xfer("rd80_post", 1'b1, 1'b0, 32'h0000_0080, pk(Z, Z, Z, Z), pk(PA, PA, P7, P8), 1'b0);
        // Both requests: served as read, no write, sticky error
        xfer("rdwr40", 1'b1, 1'b1, 32'h0000_0040, pk(PD, PD, PD, PD), pk(P1, P2, P3, P4), 1'b1);
        xfer("rd40_after", 1'b1, 1'b0, 32'h0000_0040, pk(Z, Z, Z, Z), pk(P1, P2, P3, P4), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
